// File: rtl/axilite_reg_arbiter.sv
// rtl/axilite_reg_arbiter.sv - shares one single-port RAM between the write and read register ports
// Optional feature: define AXILITE_REG_ARB_RANGE_CHECK_EN to suppress RAM access for addresses above the RAM window.
module axilite_reg_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 40,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     reg_wr_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wr_data,
    input  logic [STRB_WIDTH-1:0]     reg_wr_strb,
    input  logic                      reg_wr_en,
    output logic                      reg_wr_wait,
    output logic                      reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0]     reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [DATA_WIDTH-1:0]     reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack,
    output logic                      mem_en,
    output logic [STRB_WIDTH-1:0]     mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int OFF_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_DATA
    } state_t;

    state_t                    state_q, state_d;
    logic                      last_rd_q, last_rd_d;   // 1: read was the most recent grant
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;         // word address captured at grant
    logic                      oor_q, oor_d;           // granted address lies outside the RAM
    logic [ADDR_WIDTH-1:0]     wr_word;
    logic [ADDR_WIDTH-1:0]     rd_word;
    logic                      wr_oor;
    logic                      rd_oor;
    logic                      grant_wr;

    // Drop the byte-offset bits so the RAM sees word addresses.
    assign wr_word = reg_wr_addr >> OFF_W;
    assign rd_word = reg_rd_addr >> OFF_W;

`ifdef AXILITE_REG_ARB_RANGE_CHECK_EN
    // Any word-address bit above the RAM window marks the access as out of range.
    assign wr_oor = |(wr_word >> MEM_ADDR_WIDTH);
    assign rd_oor = |(rd_word >> MEM_ADDR_WIDTH);
`else
    // Upper bits are ignored; accesses alias modulo the RAM size.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{wr_word, rd_word};
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // Write wins when it is the only requester or when read was granted last.
    assign grant_wr = reg_wr_en & (~reg_rd_en | last_rd_q);

    // State, fairness and captured-address registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            addr_q    <= '0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            addr_q    <= addr_d;
            oor_q     <= oor_d;
        end
    end

    // Next-state arbitration and per-state RAM / ack outputs.
    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        addr_d      = addr_q;
        oor_d       = oor_q;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        reg_wr_ack  = 1'b0;
        reg_rd_ack  = 1'b0;
        reg_rd_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_d   = ST_WRITE;
                    last_rd_d = 1'b0;
                    addr_d    = wr_word[MEM_ADDR_WIDTH-1:0];
                    oor_d     = wr_oor;
                end else if (reg_rd_en) begin
                    state_d   = ST_RD_ISSUE;
                    last_rd_d = 1'b1;
                    addr_d    = rd_word[MEM_ADDR_WIDTH-1:0];
                    oor_d     = rd_oor;
                end
            end
            ST_WRITE: begin
                mem_en     = ~oor_q;
                mem_we     = oor_q ? '0 : reg_wr_strb;
                mem_addr   = addr_q;
                mem_wdata  = reg_wr_data;
                reg_wr_ack = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                mem_en   = ~oor_q;
                mem_addr = addr_q;
                state_d  = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                reg_rd_data = oor_q ? '0 : mem_rdata;
                reg_rd_ack  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending indications; forced low while reset is held.
    assign reg_wr_wait = reg_wr_en & ~reg_wr_ack & ~rst;
    assign reg_rd_wait = reg_rd_en & ~reg_rd_ack & ~rst;

endmodule

// File: tb/tb_axilite_reg_arbiter.sv
// tb/tb_axilite_reg_arbiter.sv - directed self-checking bench for axilite_reg_arbiter
module tb_axilite_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_wait;
    logic        reg_wr_ack;
    logic [39:0] reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_wait;
    logic        reg_rd_ack;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [0:1023];

    axilite_reg_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_strb (reg_wr_strb),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_wait (reg_wr_wait),
        .reg_wr_ack  (reg_wr_ack),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .reg_rd_wait (reg_rd_wait),
        .reg_rd_ack  (reg_rd_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (mem_we == 4'h0) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_en, input logic [9:0] exp_maddr);
        int  cyc;
        bit  got;
        reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
        #1 check("wr_wait_pending", reg_wr_wait, 1);
        cyc = 0; got = 0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (reg_wr_ack) begin
                got = 1;
                check("wr_latency", cyc, 1);
                check("wr_mem_en", mem_en, exp_en);
                check("wr_mem_we", mem_we, exp_en ? s : 4'h0);
                if (exp_en) check("wr_mem_addr", mem_addr, exp_maddr);
                if (exp_en) check("wr_mem_wdata", mem_wdata, d);
                check("wr_wait_at_ack", reg_wr_wait, 0);
                check("wr_no_rd_ack", reg_rd_ack, 0);
            end
        end
        if (!got) check("wr_timeout", 0, 1);
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [39:0] a, input logic exp_en, input logic [9:0] exp_maddr,
                           input logic [31:0] exp_d);
        int  cyc;
        bit  got;
        reg_rd_addr = a; reg_rd_en = 1'b1;
        #1 check("rd_wait_pending", reg_rd_wait, 1);
        cyc = 0; got = 0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check("rd_issue_mem_en", mem_en, exp_en);
                check("rd_issue_mem_we", mem_we, 0);
                if (exp_en) check("rd_issue_mem_addr", mem_addr, exp_maddr);
                check("rd_data_zero_no_ack", reg_rd_data, 0);
            end
            if (reg_rd_ack) begin
                got = 1;
                check("rd_latency", cyc, 2);
                check("rd_data", reg_rd_data, exp_d);
                check("rd_no_wr_ack", reg_wr_ack, 0);
            end
        end
        if (!got) check("rd_timeout", 0, 1);
        @(posedge clk); #1;
        reg_rd_en = 1'b0;
        check("rd_data_zero_after", reg_rd_data, 0);
    endtask

    task automatic collide(input logic [39:0] wa, input logic [31:0] wd, input logic [39:0] ra,
                           output int wc, output int rc, output logic [31:0] rdat);
        int cyc;
        bit drop_w, drop_r;
        reg_wr_addr = wa; reg_wr_data = wd; reg_wr_strb = 4'hF; reg_rd_addr = ra;
        reg_wr_en = 1'b1; reg_rd_en = 1'b1;
        cyc = 0; wc = 0; rc = 0; rdat = '0; drop_w = 0; drop_r = 0;
        while ((reg_wr_en || reg_rd_en) && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (drop_w) reg_wr_en = 1'b0;
            if (drop_r) reg_rd_en = 1'b0;
            check("ack_onehot", reg_wr_ack & reg_rd_ack, 0);
            if (reg_wr_ack) begin wc = cyc; drop_w = 1; end
            if (reg_rd_ack) begin rc = cyc; rdat = reg_rd_data; drop_r = 1; end
        end
        if (reg_wr_en || reg_rd_en) check("collide_timeout", 0, 1);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    endtask

    initial begin
        int          wc, rc, acks;
        logic [31:0] rdat;
        rst = 1'b1;
        reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
        reg_rd_addr = '0; reg_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Outputs stay zero under reset even with requests present.
        reg_wr_en = 1'b1; reg_rd_en = 1'b1;
        @(posedge clk); #1;
        check("rst_wr_wait", reg_wr_wait, 0);
        check("rst_rd_wait", reg_rd_wait, 0);
        check("rst_wr_ack", reg_wr_ack, 0);
        check("rst_rd_ack", reg_rd_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rd_data", reg_rd_data, 0);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word write then readback.
        do_write(40'h10, 32'hDEADBEEF, 4'hF, 1'b1, 10'd4);
        do_read (40'h10, 1'b1, 10'd4, 32'hDEADBEEF);

        // Partial strobe merge.
        do_write(40'h10, 32'h12345678, 4'h3, 1'b1, 10'd4);
        do_read (40'h10, 1'b1, 10'd4, 32'hDEAD5678);

        // First collision since reset: write first, read sees the new data.
        collide(40'h20, 32'hCAFEF00D, 40'h20, wc, rc, rdat);
        check("coll1_wr_cycle", wc, 1);
        check("coll1_rd_cycle", rc, 4);
        check("coll1_rd_data", rdat, 32'hCAFEF00D);

        // Make write the last grant, then collide: read must win.
        do_write(40'h30, 32'h11112222, 4'hF, 1'b1, 10'd12);
        collide(40'h30, 32'h33334444, 40'h30, wc, rc, rdat);
        check("coll2_rd_cycle", rc, 2);
        check("coll2_wr_cycle", wc, 4);
        check("coll2_rd_data", rdat, 32'h11112222);
        do_read(40'h30, 1'b1, 10'd12, 32'h33334444);

        // Address above the RAM window.
`ifdef AXILITE_REG_ARB_RANGE_CHECK_EN
        do_write(40'h1000, 32'h0BADF00D, 4'hF, 1'b0, 10'd0);
        do_read (40'h1000, 1'b0, 10'd0, 32'h0);
`else
        do_write(40'h1000, 32'h0BADF00D, 4'hF, 1'b1, 10'd0);
        do_read (40'h0,    1'b1, 10'd0, 32'h0BADF00D);
        do_read (40'h1000, 1'b1, 10'd0, 32'h0BADF00D);
`endif

        // Reset pulse during RD_ISSUE aborts the read.
        reg_rd_addr = 40'h10; reg_rd_en = 1'b1;
        @(posedge clk); #1;
        check("abort_issue_mem_en", mem_en, 1);
        rst = 1'b1;
        #1;
        check("abort_mem_en", mem_en, 0);
        check("abort_rd_ack", reg_rd_ack, 0);
        check("abort_rd_wait", reg_rd_wait, 0);
        reg_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (reg_rd_ack || reg_wr_ack) acks++;
        end
        check("abort_no_replay", acks, 0);
        do_read(40'h10, 1'b1, 10'd4, 32'hDEAD5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
